// File: rtl/sam_fanout_pkg.sv
// Shared constants and the participation-mask helper for the stream fanout fork.
// Supports up to FANOUT_MAX_OUT sinks with select words up to CFG_W_MAX bits wide.
package sam_fanout_pkg;

  localparam int FANOUT_MAX_OUT = 32;
  localparam int STALL_CNT_W    = 16;
  localparam int CFG_W_MAX      = 32;
  localparam int SEL_IDX_W      = $clog2(FANOUT_MAX_OUT * CFG_W_MAX);

  // Callers zero-extend their vectors to the maximum sizes and truncate the result to NUM_OUT.
  function automatic logic [FANOUT_MAX_OUT-1:0] part_mask(
    input logic [FANOUT_MAX_OUT-1:0]           cfg_en,
    input logic [FANOUT_MAX_OUT*CFG_W_MAX-1:0] cfg_sel,
    input int unsigned                         cfg_w,
    input int unsigned                         sel_bit
  );
    logic [SEL_IDX_W-1:0] idx;
    part_mask = '0;
    for (int unsigned i = 0; i < FANOUT_MAX_OUT; i++) begin
      idx          = SEL_IDX_W'(i * cfg_w + sel_bit);
      part_mask[i] = cfg_en[i] & cfg_sel[idx];
    end
  endfunction

endpackage

// File: rtl/stream_fanout_fork_branch.sv
// One sink of the eager fork: taken flag, gated valid, ready term for the upstream AND.
// Optional per-sink saturating stall counter under `STREAM_FANOUT_STALL_CNT_EN.
module fanout_branch
  import sam_fanout_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic fire,
  input  logic in_valid,
  input  logic part,
  input  logic out_ready,
  output logic out_valid,
  output logic ready_term
`ifdef STREAM_FANOUT_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  logic taken;

  // A taken bit survives a part drop; it is only masked while the sink is not participating.
  assign out_valid  = in_valid & part & ~taken;
  assign ready_term = ~part | taken | out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      taken <= 1'b0;
    end else if (fire) begin
      taken <= 1'b0;
    end else if (out_valid && out_ready) begin
      taken <= 1'b1;
    end
  end

`ifdef STREAM_FANOUT_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != {STALL_CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/stream_fanout_fork.sv
// Eager ready/valid fork: broadcasts each upstream token to every participating sink.
// Optional feature macro: STREAM_FANOUT_STALL_CNT_EN adds the stall_cnt output port.
module stream_fanout_fork
  import sam_fanout_pkg::*;
#(
  parameter int NUM_OUT = 20,
  parameter int DATA_W  = 17,
  parameter int CFG_W   = 8,
  parameter int SEL_BIT = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_OUT-1:0]        cfg_en,
  input  logic [NUM_OUT*CFG_W-1:0]  cfg_sel,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_ready
`ifdef STREAM_FANOUT_STALL_CNT_EN
  , output logic [NUM_OUT*STALL_CNT_W-1:0] stall_cnt
`endif
);

  logic [NUM_OUT-1:0] part;
  logic [NUM_OUT-1:0] ready_term;
  logic               fire;

  assign part = NUM_OUT'(part_mask(FANOUT_MAX_OUT'(cfg_en),
                                   (FANOUT_MAX_OUT*CFG_W_MAX)'(cfg_sel),
                                   CFG_W, SEL_BIT));

  // Retirement and the last sink's accept land on the same edge; no participants means instant drop.
  assign in_ready = &ready_term;
  assign fire     = in_valid & in_ready;
  assign out_data = {NUM_OUT{in_data}};

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_branch
    fanout_branch u_branch (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .fire       (fire),
      .in_valid   (in_valid),
      .part       (part[i]),
      .out_ready  (out_ready[i]),
      .out_valid  (out_valid[i]),
      .ready_term (ready_term[i])
`ifdef STREAM_FANOUT_STALL_CNT_EN
      , .stall_cnt (stall_cnt[i*STALL_CNT_W +: STALL_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_fanout_fork.sv
// Directed self-checking bench for stream_fanout_fork with four sinks.
// Stall-counter scenario runs only when STREAM_FANOUT_STALL_CNT_EN is defined.
module tb_stream_fanout_fork;

  localparam int NUM_OUT = 4;
  localparam int DATA_W  = 17;
  localparam int CFG_W   = 8;
  localparam int SEL_BIT = 5;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [NUM_OUT-1:0]        cfg_en;
  logic [NUM_OUT*CFG_W-1:0]  cfg_sel;
  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_ready;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_ready;
`ifdef STREAM_FANOUT_STALL_CNT_EN
  logic [NUM_OUT*16-1:0]     stall_cnt;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  stream_fanout_fork #(
    .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CFG_W(CFG_W), .SEL_BIT(SEL_BIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cfg_en    (cfg_en),
    .cfg_sel   (cfg_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef STREAM_FANOUT_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Select words with unrelated bits set, so only SEL_BIT decides participation.
  function automatic logic [NUM_OUT*CFG_W-1:0] sel_words(input logic [NUM_OUT-1:0] m);
    logic [CFG_W-1:0] w;
    sel_words = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w = 8'h9A;
      w[SEL_BIT] = m[i];
      sel_words[i*CFG_W +: CFG_W] = w;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_part(input logic [NUM_OUT-1:0] m);
    cfg_en  = 4'b1111;
    cfg_sel = sel_words(m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 17'h0_1234;
    out_ready = 4'b0000;
    set_part(4'b1011);
    tick(); tick();
    #1;
    check_cnt++;
    if (out_valid !== 4'b1011) $display("FAIL reset_valid got %b want %b", out_valid, 4'b1011);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", in_ready);
    else pass_cnt++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_broadcast();
    set_part(4'b1011);
    out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 17'h1_ABCD;
    #1;
    check_cnt++;
    if (out_valid !== 4'b1011) $display("FAIL bcast_valid got %b want %b", out_valid, 4'b1011);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bcast_ready got %b want 1", in_ready);
    else pass_cnt++;
    check_cnt++;
    if (out_data !== {4{17'h1_ABCD}}) $display("FAIL bcast_data got %h want %h", out_data, {4{17'h1_ABCD}});
    else pass_cnt++;
    tick();
    // Token retired in one cycle: the next token is presented to every sink again.
    in_data = 17'h0_5555;
    #1;
    check_cnt++;
    if (out_valid !== 4'b1011) $display("FAIL bcast_next_valid got %b want %b", out_valid, 4'b1011);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  // Sinks 0,1 accept first, sink 2 late; each sink's valid falls after its own accept.
  task automatic test_partial();
    logic [NUM_OUT-1:0] rdy_seq [3] = '{4'b0011, 4'b0000, 4'b0100};
    logic [NUM_OUT-1:0] vld_exp [3] = '{4'b0111, 4'b0100, 4'b0100};
    logic               rdy_exp [3] = '{1'b0, 1'b0, 1'b1};
    set_part(4'b0111);
    in_valid = 1'b1; in_data = 17'h0_0F0F;
    for (int c = 0; c < 3; c++) begin
      out_ready = rdy_seq[c];
      #1;
      check_cnt++;
      if (out_valid !== vld_exp[c]) $display("FAIL partial_valid c%0d got %b want %b", c, out_valid, vld_exp[c]);
      else pass_cnt++;
      check_cnt++;
      if (in_ready !== rdy_exp[c]) $display("FAIL partial_ready c%0d got %b want %b", c, in_ready, rdy_exp[c]);
      else pass_cnt++;
      tick();
    end
    out_ready = 4'b0000;
    #1;
    check_cnt++;
    if (out_valid !== 4'b0111) $display("FAIL partial_next got %b want %b", out_valid, 4'b0111);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  // Sink 0 ready in cycle 0, sink 1 only in cycle 3.
  task automatic test_order();
    logic [NUM_OUT-1:0] rdy_seq [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
    logic [NUM_OUT-1:0] vld_exp [4] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010};
    logic               rdy_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_part(4'b0011);
    in_valid = 1'b1; in_data = 17'h1_0001;
    for (int c = 0; c < 4; c++) begin
      out_ready = rdy_seq[c];
      #1;
      check_cnt++;
      if (out_valid !== vld_exp[c]) $display("FAIL order_valid c%0d got %b want %b", c, out_valid, vld_exp[c]);
      else pass_cnt++;
      check_cnt++;
      if (in_ready !== rdy_exp[c]) $display("FAIL order_ready c%0d got %b want %b", c, in_ready, rdy_exp[c]);
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 4'b0000;
    tick();
  endtask

  task automatic test_no_part();
    logic [NUM_OUT-1:0]       en_tab  [2] = '{4'b0000, 4'b1111};
    logic [NUM_OUT*CFG_W-1:0] sel_tab [2];
    sel_tab[0] = sel_words(4'b1111);
    sel_tab[1] = {4{8'hDF}};
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 17'h0_7777;
    for (int k = 0; k < 2; k++) begin
      cfg_en = en_tab[k]; cfg_sel = sel_tab[k];
      for (int c = 0; c < 2; c++) begin
        #1;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL nopart_ready k%0d c%0d got %b want 1", k, c, in_ready);
        else pass_cnt++;
        check_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL nopart_valid k%0d c%0d got %b want 0000", k, c, out_valid);
        else pass_cnt++;
        tick();
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  // Half-taken token cleared by flush (k=0) or reset (k=1); sink 0 sees it again.
  task automatic test_flush_reset();
    set_part(4'b0011);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 17'h1_2345;
      out_ready = 4'b0001;
      tick();
      out_ready = 4'b0000;
      #1;
      check_cnt++;
      if (out_valid !== 4'b0010) $display("FAIL clr%0d_half got %b want %b", k, out_valid, 4'b0010);
      else pass_cnt++;
      if (k == 0) flush = 1'b1;
      else rst_n = 1'b0;
      tick();
      flush = 1'b0; rst_n = 1'b1;
      #1;
      check_cnt++;
      if (out_valid !== 4'b0011) $display("FAIL clr%0d_again got %b want %b", k, out_valid, 4'b0011);
      else pass_cnt++;
      out_ready = 4'b0011;
      tick();
      out_ready = 4'b0000;
      in_valid = 1'b0;
      tick();
    end
  endtask

  // A sink dropping out mid-token keeps its taken bit masked, not cleared.
  task automatic test_part_drop();
    set_part(4'b0011);
    in_valid = 1'b1; in_data = 17'h0_0ACE;
    out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    cfg_en = 4'b1110;
    #1;
    check_cnt++;
    if (out_valid !== 4'b0010 || in_ready !== 1'b0)
      $display("FAIL drop_masked got v=%b r=%b want v=0010 r=0", out_valid, in_ready);
    else pass_cnt++;
    tick();
    cfg_en = 4'b1111;
    #1;
    check_cnt++;
    if (out_valid !== 4'b0010) $display("FAIL drop_kept got %b want %b", out_valid, 4'b0010);
    else pass_cnt++;
    cfg_en = 4'b1101;
    #1;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL drop_retire got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    cfg_en = 4'b1111;
    tick();
  endtask

`ifdef STREAM_FANOUT_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    set_part(4'b0111);
    in_valid = 1'b0;
    out_ready = 4'b1011;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 17'h1_FFFF;
    for (int c = 0; c < 70000; c++) @(posedge clk);
    #1;
    check_cnt++;
    if (stall_cnt[2*16 +: 16] !== 16'hFFFF) $display("FAIL stall_sat got %h want FFFF", stall_cnt[2*16 +: 16]);
    else pass_cnt++;
    check_cnt++;
    if (stall_cnt[0 +: 16] !== 16'h0 || stall_cnt[16 +: 16] !== 16'h0 || stall_cnt[48 +: 16] !== 16'h0)
      $display("FAIL stall_others got %h want 0", stall_cnt);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; cfg_en = '0; cfg_sel = '0;
    in_valid = 1'b0; in_data = '0; out_ready = '0;
    test_reset();
    test_broadcast();
    test_partial();
    test_order();
    test_no_part();
    test_flush_reset();
    test_part_drop();
`ifdef STREAM_FANOUT_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
